// File: rtl/ram_pkg.sv
// Shared types and helpers for the banked RAM.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ram_state_t;

  localparam int unsigned DEFAULT_WIDTH = 16;

  // Ceiling log2 for elaboration-time width derivation.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/ram_bank.sv
// One sub-bank: single write port, combinational read of the addressed word.
module ram_bank
  import ram_pkg::*;
#(
  parameter int unsigned WIDTH      = DEFAULT_WIDTH,
  parameter int unsigned BANK_DEPTH = 8,
  parameter int unsigned BADDR_W    = clog2(BANK_DEPTH)
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [BADDR_W-1:0] addr_i,
  input  logic [WIDTH-1:0]   wdata_i,
  output logic [WIDTH-1:0]   rdata_o
);

  logic [WIDTH-1:0] mem_q [BANK_DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ram_banked.sv
// Banked RAM with registered read, selectable read-during-write and a
// clear engine that zeroes every word after reset or on request.
module ram_banked
  import ram_pkg::*;
#(
  parameter int unsigned WIDTH      = DEFAULT_WIDTH,
  parameter int unsigned BANKS      = 8,
  parameter int unsigned BANK_DEPTH = 8,
  parameter bit          RDW_NEW    = 1'b0
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [WIDTH-1:0]                           in,
  input  logic [clog2(BANKS)+clog2(BANK_DEPTH)-1:0]  address,
  input  logic                                       load,
  input  logic                                       rd_en,
  input  logic                                       clear,
  output logic [WIDTH-1:0]                           out,
  output logic                                       out_valid,
  output logic                                       busy
);

  localparam int unsigned BSEL_W  = clog2(BANKS);
  localparam int unsigned BADDR_W = clog2(BANK_DEPTH);
  localparam int unsigned ADDR_W  = BSEL_W + BADDR_W;

  ram_state_t         state_q;
  logic [BADDR_W-1:0] ptr_q;
  logic [WIDTH-1:0]   out_q;
  logic               out_valid_q;
  logic               busy_q;

  logic [BSEL_W-1:0]  bsel_c;
  logic [BADDR_W-1:0] bank_addr_c;
  logic [WIDTH-1:0]   bank_wdata_c;
  logic [BANKS-1:0]   bank_we_c;
  logic [WIDTH-1:0]   rdata_c [BANKS];
  logic [WIDTH-1:0]   rd_word_c;

  assign bsel_c = address[ADDR_W-1:BADDR_W];

  // Bank port steering: the sweep owns every bank, otherwise only the addressed bank writes.
  always_comb begin
    bank_we_c    = '0;
    bank_addr_c  = address[BADDR_W-1:0];
    bank_wdata_c = in;
    if (!reset) begin
      if (state_q == CLEAR) begin
        bank_addr_c  = ptr_q;
        bank_wdata_c = '0;
        bank_we_c    = '1;
      end else if (!clear && load) begin
        bank_we_c[bsel_c] = 1'b1;
      end
    end
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    ram_bank #(
      .WIDTH      (WIDTH),
      .BANK_DEPTH (BANK_DEPTH),
      .BADDR_W    (BADDR_W)
    ) u_bank (
      .clk     (clk),
      .we_i    (bank_we_c[b]),
      .addr_i  (bank_addr_c),
      .wdata_i (bank_wdata_c),
      .rdata_o (rdata_c[b])
    );
  end

  // Bank read is pre-edge contents; forwarding the write data gives new-data semantics.
  assign rd_word_c = (RDW_NEW && load) ? in : rdata_c[bsel_c];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= CLEAR;
      ptr_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        CLEAR: begin
          ptr_q <= ptr_q + BADDR_W'(1);
          if (ptr_q == BADDR_W'(BANK_DEPTH - 1)) begin
            state_q <= READY;
            busy_q  <= 1'b0;
          end
        end
        READY: begin
          if (clear) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end else if (rd_en) begin
            out_q       <= rd_word_c;
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= CLEAR;
          ptr_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ram_banked.sv
// Self-checking bench: default 8x8x16 RAM (old-data RDW) and a 4x16x8 RAM (new-data RDW).
module tb_ram_banked;

  logic        clk;
  logic        rst_a, load_a, rd_a, clr_a, v_a, busy_a;
  logic [15:0] in_a, out_a;
  logic [5:0]  addr_a;
  logic        rst_b, load_b, rd_b, clr_b, v_b, busy_b;
  logic [7:0]  in_b, out_b;
  logic [5:0]  addr_b;

  ram_banked u_dut_a (
    .clk(clk), .reset(rst_a), .in(in_a), .address(addr_a), .load(load_a),
    .rd_en(rd_a), .clear(clr_a), .out(out_a), .out_valid(v_a), .busy(busy_a)
  );

  ram_banked #(.WIDTH(8), .BANKS(4), .BANK_DEPTH(16), .RDW_NEW(1'b1)) u_dut_b (
    .clk(clk), .reset(rst_b), .in(in_b), .address(addr_b), .load(load_b),
    .rd_en(rd_b), .clear(clr_b), .out(out_b), .out_valid(v_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  logic [15:0] ma [64];
  logic [7:0]  mb [64];

  typedef struct {
    logic        ld;
    logic        rd;
    logic [5:0]  ad;
    logic [15:0] d;
    logic        ev;
    logic [15:0] eo;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc_a(input logic ld, input logic rd, input logic cl,
                       input logic [5:0] ad, input logic [15:0] d);
    load_a = ld; rd_a = rd; clr_a = cl; addr_a = ad; in_a = d;
    @(posedge clk); #1;
  endtask

  task automatic cyc_b(input logic ld, input logic rd,
                       input logic [5:0] ad, input logic [7:0] d);
    load_b = ld; rd_b = rd; clr_b = 1'b0; addr_b = ad; in_b = d;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a_drop, b_drop, n;
    logic [15:0] eo_a, d16;
    logic [7:0]  eo_b, d8;
    logic        ld, rd;
    logic [5:0]  ad;

    rst_a = 1'b1; load_a = 1'b0; rd_a = 1'b0; clr_a = 1'b0; addr_a = '0; in_a = '0;
    rst_b = 1'b1; load_b = 1'b0; rd_b = 1'b0; clr_b = 1'b0; addr_b = '0; in_b = '0;
    @(posedge clk); #1;
    chk("rst_busy_a", 32'(busy_a), 32'd1);
    chk("rst_valid_a", 32'(v_a), 32'd0);
    chk("rst_out_a", 32'(out_a), 32'd0);
    chk("rst_busy_b", 32'(busy_b), 32'd1);
    chk("rst_out_b", 32'(out_b), 32'd0);

    // Initial sweep length: 8 cycles for A, 16 for B
    rst_a = 1'b0; rst_b = 1'b0;
    a_drop = 0; b_drop = 0;
    for (int i = 1; i <= 24; i++) begin
      @(posedge clk); #1;
      if (!busy_a && a_drop == 0) a_drop = i;
      if (!busy_b && b_drop == 0) b_drop = i;
    end
    chk("sweep_len_a", 32'(a_drop), 32'd8);
    chk("sweep_len_b", 32'(b_drop), 32'd16);
    for (int i = 0; i < 64; i++) begin ma[i] = '0; mb[i] = '0; end

    // Every word reads zero, back-to-back
    for (int i = 0; i < 64; i++) begin
      cyc_a(1'b0, 1'b1, 1'b0, 6'(i), 16'h0);
      chk("zero_valid", 32'(v_a), 32'd1);
      chk("zero_out", 32'(out_a), 32'd0);
    end
    cyc_a(1'b0, 1'b0, 1'b0, 6'h0, 16'h0);
    chk("idle_valid", 32'(v_a), 32'd0);

    tbl[0]  = '{1'b1, 1'b0, 6'h00, 16'hBEEF, 1'b0, 16'h0000};
    tbl[1]  = '{1'b1, 1'b0, 6'h3F, 16'h1234, 1'b0, 16'h0000};
    tbl[2]  = '{1'b1, 1'b0, 6'h09, 16'hA5A5, 1'b0, 16'h0000};
    tbl[3]  = '{1'b0, 1'b1, 6'h00, 16'h0000, 1'b1, 16'hBEEF};
    tbl[4]  = '{1'b0, 1'b1, 6'h3F, 16'h0000, 1'b1, 16'h1234};
    tbl[5]  = '{1'b0, 1'b1, 6'h09, 16'h0000, 1'b1, 16'hA5A5};
    tbl[6]  = '{1'b0, 1'b1, 6'h08, 16'h0000, 1'b1, 16'h0000};
    tbl[7]  = '{1'b0, 1'b1, 6'h3E, 16'h0000, 1'b1, 16'h0000};
    tbl[8]  = '{1'b1, 1'b0, 6'h15, 16'h1111, 1'b0, 16'h0000};
    tbl[9]  = '{1'b1, 1'b1, 6'h15, 16'h2222, 1'b1, 16'h1111};
    tbl[10] = '{1'b0, 1'b1, 6'h15, 16'h0000, 1'b1, 16'h2222};
    tbl[11] = '{1'b0, 1'b0, 6'h15, 16'h0000, 1'b0, 16'h2222};
    tbl[12] = '{1'b0, 1'b1, 6'h3F, 16'h0000, 1'b1, 16'h1234};
    for (int i = 0; i < 13; i++) begin
      cyc_a(tbl[i].ld, tbl[i].rd, 1'b0, tbl[i].ad, tbl[i].d);
      if (tbl[i].ld) ma[tbl[i].ad] = tbl[i].d;
      chk($sformatf("tbl%0d_valid", i), 32'(v_a), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_out", i), 32'(out_a), 32'(tbl[i].eo));
    end

    // Random traffic on A against the array model (old-data RDW)
    eo_a = 16'h1234;
    for (int i = 0; i < 400; i++) begin
      ld  = 1'($urandom_range(0, 1));
      rd  = 1'($urandom_range(0, 1));
      ad  = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(20, 22)) : 6'($urandom);
      d16 = 16'($urandom);
      cyc_a(ld, rd, 1'b0, ad, d16);
      if (rd) eo_a = ma[ad];
      if (ld) ma[ad] = d16;
      chk("rand_a_valid", 32'(v_a), 32'(rd));
      chk("rand_a_out", 32'(out_a), 32'(eo_a));
    end
    cyc_a(1'b0, 1'b0, 1'b0, 6'h0, 16'h0);

    // Clear pulse wins over a same-cycle load
    cyc_a(1'b1, 1'b0, 1'b1, 6'h05, 16'h7777);
    chk("clr_busy", 32'(busy_a), 32'd1);
    chk("clr_valid", 32'(v_a), 32'd0);
    n = 0;
    while (busy_a && n < 40) begin
      cyc_a(1'b0, 1'b0, 1'b0, 6'h0, 16'h0);
      n++;
    end
    chk("clr_sweep_len", 32'(n), 32'd8);
    cyc_a(1'b0, 1'b1, 1'b0, 6'h05, 16'h0);
    chk("clr_rd05_valid", 32'(v_a), 32'd1);
    chk("clr_rd05_out", 32'(out_a), 32'd0);
    cyc_a(1'b0, 1'b1, 1'b0, 6'h3F, 16'h0);
    chk("clr_rd3f_out", 32'(out_a), 32'd0);

    // Reset coinciding with a read cancels out_valid
    cyc_a(1'b1, 1'b0, 1'b0, 6'h15, 16'h4242);
    rst_a = 1'b1;
    cyc_a(1'b0, 1'b1, 1'b0, 6'h15, 16'h0);
    chk("rstrd_valid", 32'(v_a), 32'd0);
    chk("rstrd_busy", 32'(busy_a), 32'd1);
    chk("rstrd_out", 32'(out_a), 32'd0);
    rst_a = 1'b0;
    for (int i = 0; i < 3; i++) cyc_a(1'b0, 1'b0, 1'b0, 6'h0, 16'h0);
    chk("midsweep_busy", 32'(busy_a), 32'd1);
    rst_a = 1'b1;
    cyc_a(1'b0, 1'b1, 1'b0, 6'h15, 16'h0);
    chk("midsweep_rst_valid", 32'(v_a), 32'd0);
    rst_a = 1'b0;
    n = 0;
    while (busy_a && n < 40) begin
      cyc_a(1'b0, 1'b0, 1'b0, 6'h0, 16'h0);
      n++;
    end
    chk("midsweep_restart_len", 32'(n), 32'd8);
    cyc_a(1'b0, 1'b1, 1'b0, 6'h15, 16'h0);
    chk("midsweep_rd15_out", 32'(out_a), 32'd0);
    cyc_a(1'b0, 1'b0, 1'b0, 6'h0, 16'h0);

    // B: address-as-data across all 64 words
    for (int i = 0; i < 64; i++) begin
      cyc_b(1'b1, 1'b0, 6'(i), 8'(i));
      mb[i] = 8'(i);
    end
    for (int i = 0; i < 64; i++) begin
      cyc_b(1'b0, 1'b1, 6'(i), 8'h0);
      chk("b_fill_valid", 32'(v_b), 32'd1);
      chk("b_fill_out", 32'(out_b), 32'(i));
    end

    // Random traffic on B against the array model (new-data RDW)
    eo_b = 8'd63;
    for (int i = 0; i < 300; i++) begin
      ld = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      ad = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(0, 2)) : 6'($urandom);
      d8 = 8'($urandom);
      cyc_b(ld, rd, ad, d8);
      if (ld) mb[ad] = d8;
      if (rd) eo_b = mb[ad];
      chk("rand_b_valid", 32'(v_b), 32'(rd));
      chk("rand_b_out", 32'(out_b), 32'(eo_b));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
